// File: rtl/game_status_scan_pkg.sv
// Shared definitions for the frame status scanner: FSM encoding, default
// geometry and the square overlap test.
package game_status_scan_pkg;

  localparam int DEF_MAX_SEG = 33;
  localparam int DEF_CW      = 10;
  localparam int DEF_SQ      = 10;
  localparam int DEF_SCR_W   = 640;
  localparam int DEF_SCR_H   = 480;

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    SCAN,
    FINISH,
    OVER
  } state_t;

  // Two squares of side sq overlap when both origin deltas lie strictly inside (-sq, sq).
  function automatic logic overlap(input int dx, input int dy, input int sq);
    return (dx < sq) && (dx > -sq) && (dy < sq) && (dy > -sq);
  endfunction

endpackage

// File: rtl/game_status_scan_square_overlap.sv
// Combinational overlap test between two squares given by their origins.
module square_overlap
  import game_status_scan_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int SQ = DEF_SQ
) (
  input  logic [CW-1:0] ax,
  input  logic [CW-1:0] ay,
  input  logic [CW-1:0] bx,
  input  logic [CW-1:0] by,
  output logic          hit
);

  logic signed [CW:0] dx;
  logic signed [CW:0] dy;

  always_comb begin
    dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
    hit = overlap(int'(dx), int'(dy), SQ);
  end

endmodule

// File: rtl/game_status_scan.sv
// Per-frame game status evaluation: wall, food and self-collision checks on a
// snapshot of the snake, one body segment per cycle.
module game_status_scan
  import game_status_scan_pkg::*;
#(
  parameter int MAX_SEG = DEF_MAX_SEG,
  parameter int CW      = DEF_CW,
  parameter int SQ      = DEF_SQ,
  parameter int SCR_W   = DEF_SCR_W,
  parameter int SCR_H   = DEF_SCR_H
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           refresh_tick,
  input  logic [2*CW*MAX_SEG-1:0]        position,
  input  logic [CW-1:0]                  food_x,
  input  logic [CW-1:0]                  food_y,
  input  logic                           wrap_en,
  output logic                           status,
  output logic [$clog2(MAX_SEG+1)-1:0]   num_squares,
  output logic                           food_eaten,
  output logic                           done,
  output logic                           busy,
  output logic                           overrun
);

  localparam int NW = $clog2(MAX_SEG+1);

  state_t state, state_nxt;

  logic [2*CW*MAX_SEG-1:0] pos_snap;
  logic [CW-1:0]           fx_snap, fy_snap;
  logic                    wrap_snap;
  logic [CW-1:0]           head_x, head_y;
  logic                    collision, food_hit;
  logic [NW-1:0]           idx;

  logic [CW-1:0]   hx_raw, hy_raw, hx_eff, hy_eff;
  logic            wall_hit;
  logic [2*CW-1:0] seg;
  logic            food_ov, seg_ov;

  always_comb begin
    hx_raw   = pos_snap[2*CW*MAX_SEG-1 -: CW];
    hy_raw   = pos_snap[2*CW*MAX_SEG-1-CW -: CW];
    wall_hit = (int'(hx_raw) > SCR_W - SQ) || (int'(hy_raw) > SCR_H - SQ);
    // In wrap mode the head is folded back onto the screen before any compare.
    hx_eff   = wrap_snap ? CW'(int'(hx_raw) % SCR_W) : hx_raw;
    hy_eff   = wrap_snap ? CW'(int'(hy_raw) % SCR_H) : hy_raw;
  end

  always_comb begin
    seg = '0;
    for (int unsigned k = 0; k < MAX_SEG; k++) begin
      if (32'(idx) == k) seg = pos_snap[2*CW*(MAX_SEG-k)-1 -: 2*CW];
    end
  end

  square_overlap #(.CW(CW), .SQ(SQ)) u_food_overlap (
    .ax  (hx_eff),
    .ay  (hy_eff),
    .bx  (fx_snap),
    .by  (fy_snap),
    .hit (food_ov)
  );

  square_overlap #(.CW(CW), .SQ(SQ)) u_seg_overlap (
    .ax  (head_x),
    .ay  (head_y),
    .bx  (seg[2*CW-1 -: CW]),
    .by  (seg[CW-1:0]),
    .hit (seg_ov)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (refresh_tick && status) state_nxt = HEAD;
      HEAD:    state_nxt = (num_squares <= NW'(1)) ? FINISH : SCAN;
      SCAN:    if (idx == num_squares - NW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = collision ? OVER : IDLE;
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == HEAD) || (state == SCAN) || (state == FINISH);
    done       = (state == FINISH);
    food_eaten = (state == FINISH) && !collision && food_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_snap    <= '0;
      fx_snap     <= '0;
      fy_snap     <= '0;
      wrap_snap   <= 1'b0;
      head_x      <= '0;
      head_y      <= '0;
      collision   <= 1'b0;
      food_hit    <= 1'b0;
      idx         <= '0;
      status      <= 1'b1;
      num_squares <= NW'(1);
      overrun     <= 1'b0;
    end else begin
      if (refresh_tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (refresh_tick && status) begin
          pos_snap  <= position;
          fx_snap   <= food_x;
          fy_snap   <= food_y;
          wrap_snap <= wrap_en;
        end
        HEAD: begin
          head_x    <= hx_eff;
          head_y    <= hy_eff;
          collision <= wall_hit && !wrap_snap;
          food_hit  <= food_ov;
          idx       <= NW'(1);
        end
        SCAN: begin
          if (seg_ov) collision <= 1'b1;
          idx <= idx + NW'(1);
        end
        FINISH: begin
          if (collision) status <= 1'b0;
          else if (food_hit && num_squares != NW'(MAX_SEG))
            num_squares <= num_squares + NW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_status_scan.sv
// Directed self-checking bench for game_status_scan with default geometry.
module tb_game_status_scan;

  localparam int MAX_SEG = 33;
  localparam int CW      = 10;
  localparam int NW      = $clog2(MAX_SEG+1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic refresh_tick = 1'b0;
  logic wrap_en = 1'b0;
  logic [2*CW*MAX_SEG-1:0] position = '0;
  logic [CW-1:0] food_x = '0;
  logic [CW-1:0] food_y = '0;
  logic status, food_eaten, done, busy, overrun;
  logic [NW-1:0] num_squares;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  game_status_scan #(
    .MAX_SEG (MAX_SEG),
    .CW      (CW),
    .SQ      (10),
    .SCR_W   (640),
    .SCR_H   (480)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .refresh_tick (refresh_tick),
    .position     (position),
    .food_x       (food_x),
    .food_y       (food_y),
    .wrap_en      (wrap_en),
    .status       (status),
    .num_squares  (num_squares),
    .food_eaten   (food_eaten),
    .done         (done),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic set_slot(input int k, input int x, input int y);
    position[2*CW*(MAX_SEG-k)-1 -: 2*CW] = {CW'(x), CW'(y)};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    refresh_tick = 1'b0;
    position = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One frame: tick, optionally swap the live position during the scan,
  // return tick-to-done latency and food_eaten at done, settle one cycle.
  task automatic do_frame(input bit use_alt, input logic [2*CW*MAX_SEG-1:0] alt,
                          output int lat, output bit fe);
    logic [2*CW*MAX_SEG-1:0] saved;
    saved = position;
    @(negedge clk);
    refresh_tick = 1'b1;
    @(negedge clk);
    refresh_tick = 1'b0;
    if (use_alt) position = alt;
    lat = 1;
    fe = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    fe = food_eaten;
    @(negedge clk);
    position = saved;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (status !== 1'b1) begin mismatched++; $display("FAIL reset_status: got %b want 1", status); end
    compared++; if (num_squares !== NW'(1)) begin mismatched++; $display("FAIL reset_num: got %0d want 1", num_squares); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (overrun !== 1'b0 || done !== 1'b0 || food_eaten !== 1'b0) begin
      mismatched++; $display("FAIL reset_pulses: got ov=%b done=%b fe=%b want 0 0 0", overrun, done, food_eaten);
    end
    set_slot(0, 100, 100);
    food_x = 400; food_y = 400;
    reset_n = 1'b1;
    refresh_tick = 1'b1;
    @(negedge clk);
    refresh_tick = 1'b0;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL first_tick_busy: got %b want 1", busy); end
    @(negedge clk);
    compared++; if (done !== 1'b1 || food_eaten !== 1'b0) begin
      mismatched++; $display("FAIL first_tick_done: got done=%b fe=%b want 1 0", done, food_eaten);
    end
    @(negedge clk);
    compared++; if (status !== 1'b1 || num_squares !== NW'(1) || busy !== 1'b0) begin
      mismatched++; $display("FAIL first_tick_after: got st=%b n=%0d busy=%b want 1 1 0", status, num_squares, busy);
    end
  endtask

  task automatic test_food();
    int lat; bit fe;
    apply_reset();
    wrap_en = 1'b0;
    set_slot(0, 200, 150);
    food_x = 205; food_y = 155;
    do_frame(1'b0, '0, lat, fe);
    compared++; if (lat != 2) begin mismatched++; $display("FAIL food_latency: got %0d want 2", lat); end
    compared++; if (fe !== 1'b1) begin mismatched++; $display("FAIL food_eaten: got %b want 1", fe); end
    compared++; if (num_squares !== NW'(2) || status !== 1'b1) begin
      mismatched++; $display("FAIL food_grow: got n=%0d st=%b want 2 1", num_squares, status);
    end
    set_slot(1, 190, 150);
    do_frame(1'b0, '0, lat, fe);
    compared++; if (lat != 3 || fe !== 1'b1 || num_squares !== NW'(3)) begin
      mismatched++; $display("FAIL food_second: got lat=%0d fe=%b n=%0d want 3 1 3", lat, fe, num_squares);
    end
  endtask

  task automatic test_self_collision();
    int lat; bit fe; int cnt;
    logic [2*CW*MAX_SEG-1:0] alt;
    set_slot(0, 300, 220);
    set_slot(1, 100, 100);
    set_slot(2, 305, 225);
    food_x = 500; food_y = 400;
    alt = position;
    alt[2*CW*(MAX_SEG-2)-1 -: 2*CW] = {CW'(600), CW'(20)};
    do_frame(1'b1, alt, lat, fe);
    compared++; if (lat != 4) begin mismatched++; $display("FAIL self_latency: got %0d want 4", lat); end
    compared++; if (status !== 1'b0) begin mismatched++; $display("FAIL self_status: got %b want 0", status); end
    compared++; if (num_squares !== NW'(3) || fe !== 1'b0) begin
      mismatched++; $display("FAIL self_num: got n=%0d fe=%b want 3 0", num_squares, fe);
    end
    cnt = 0;
    @(negedge clk); refresh_tick = 1'b1;
    @(negedge clk); refresh_tick = 1'b0;
    repeat (6) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) cnt++; end
    compared++; if (cnt != 0) begin mismatched++; $display("FAIL over_ignores_tick: got %0d active cycles want 0", cnt); end
    compared++; if (status !== 1'b0 || overrun !== 1'b0 || num_squares !== NW'(3)) begin
      mismatched++; $display("FAIL over_hold: got st=%b ov=%b n=%0d want 0 0 3", status, overrun, num_squares);
    end
  endtask

  task automatic test_wall();
    int lat; bit fe;
    apply_reset();
    wrap_en = 1'b0;
    set_slot(0, 635, 100);
    food_x = 630; food_y = 100;
    do_frame(1'b0, '0, lat, fe);
    compared++; if (lat != 2 || status !== 1'b0) begin
      mismatched++; $display("FAIL wall_kill: got lat=%0d st=%b want 2 0", lat, status);
    end
    compared++; if (fe !== 1'b0 || num_squares !== NW'(1)) begin
      mismatched++; $display("FAIL wall_collision_wins: got fe=%b n=%0d want 0 1", fe, num_squares);
    end
    apply_reset();
    wrap_en = 1'b1;
    set_slot(0, 635, 100);
    food_x = 400; food_y = 400;
    do_frame(1'b0, '0, lat, fe);
    compared++; if (status !== 1'b1 || fe !== 1'b0) begin
      mismatched++; $display("FAIL wall_wrap: got st=%b fe=%b want 1 0", status, fe);
    end
    apply_reset();
    wrap_en = 1'b0;
    set_slot(0, 630, 470);
    do_frame(1'b0, '0, lat, fe);
    compared++; if (status !== 1'b1) begin mismatched++; $display("FAIL wall_edge: got %b want 1", status); end
    apply_reset();
    wrap_en = 1'b1;
    set_slot(0, 645, 100);
    food_x = 0; food_y = 100;
    do_frame(1'b0, '0, lat, fe);
    compared++; if (status !== 1'b1 || fe !== 1'b1 || num_squares !== NW'(2)) begin
      mismatched++; $display("FAIL wrap_food: got st=%b fe=%b n=%0d want 1 1 2", status, fe, num_squares);
    end
    wrap_en = 1'b0;
  endtask

  task automatic test_overrun();
    int cnt; int fcnt;
    logic [2*CW*MAX_SEG-1:0] saved;
    apply_reset();
    set_slot(0, 100, 100);
    food_x = 400; food_y = 400;
    saved = position;
    cnt = 0; fcnt = 0;
    @(negedge clk); refresh_tick = 1'b1;
    @(negedge clk);
    if (done === 1'b1) cnt++;
    set_slot(0, 400, 400);
    @(negedge clk);
    if (done === 1'b1) cnt++;
    if (food_eaten === 1'b1) fcnt++;
    refresh_tick = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
      if (food_eaten === 1'b1) fcnt++;
    end
    position = saved;
    compared++; if (cnt != 1) begin mismatched++; $display("FAIL overrun_single_done: got %0d want 1", cnt); end
    compared++; if (overrun !== 1'b1) begin mismatched++; $display("FAIL overrun_flag: got %b want 1", overrun); end
    compared++; if (fcnt != 0 || num_squares !== NW'(1) || status !== 1'b1) begin
      mismatched++; $display("FAIL overrun_snapshot: got fe=%0d n=%0d st=%b want 0 1 1", fcnt, num_squares, status);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit fe;
    apply_reset();
    set_slot(0, 200, 150);
    food_x = 205; food_y = 155;
    for (int i = 1; i < MAX_SEG; i++) begin
      do_frame(1'b0, '0, lat, fe);
      compared++; if (lat != i + 1 || fe !== 1'b1 || num_squares !== NW'(i + 1)) begin
        mismatched++; $display("FAIL grow_%0d: got lat=%0d fe=%b n=%0d want %0d 1 %0d", i, lat, fe, num_squares, i + 1, i + 1);
      end
    end
    do_frame(1'b0, '0, lat, fe);
    compared++; if (lat != MAX_SEG + 1 || fe !== 1'b1 || num_squares !== NW'(MAX_SEG)) begin
      mismatched++; $display("FAIL saturate: got lat=%0d fe=%b n=%0d want %0d 1 %0d", lat, fe, num_squares, MAX_SEG + 1, MAX_SEG);
    end
    @(negedge clk); refresh_tick = 1'b1;
    @(negedge clk); refresh_tick = 1'b0;
    repeat (4) @(negedge clk);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL mid_scan_busy: got %b want 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    compared++; if (status !== 1'b1 || num_squares !== NW'(1) || busy !== 1'b0) begin
      mismatched++; $display("FAIL async_reset_state: got st=%b n=%0d busy=%b want 1 1 0", status, num_squares, busy);
    end
    compared++; if (done !== 1'b0 || food_eaten !== 1'b0 || overrun !== 1'b0) begin
      mismatched++; $display("FAIL async_reset_pulses: got done=%b fe=%b ov=%b want 0 0 0", done, food_eaten, overrun);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_food();
    test_self_collision();
    test_wall();
    test_overrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
